// File: rtl/draw_scheduler.sv
// Arbitrates the shared VGA write port between the board painter and the piece painter:
// full repaint, or erase-old / gap / draw-new for a piece move, with a per-phase watchdog.
module draw_scheduler #(
    parameter int WATCHDOG = 4095
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       redraw_req,
    input  logic       move_req,
    input  logic [4:0] old_x,
    input  logic [5:0] old_y,
    input  logic [2:0] old_block,
    input  logic [4:0] new_x,
    input  logic [5:0] new_y,
    input  logic [2:0] new_block,
    input  logic [7:0] board_X,
    input  logic [6:0] board_Y,
    input  logic [5:0] board_colour,
    input  logic       board_finished,
    output logic       board_enable,
    input  logic [7:0] tet_X,
    input  logic [6:0] tet_Y,
    input  logic [5:0] tet_colour,
    input  logic       tet_complete,
    output logic       tet_enable,
    output logic       tet_clear,
    output logic [2:0] tet_block,
    output logic [4:0] tet_x_in,
    output logic [5:0] tet_y_in,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [5:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done,
    output logic       timeout
);
    typedef enum logic [2:0] {IDLE, BOARD, ERASE, GAP, DRAW, FINISH} state_t;

    localparam logic [11:0] WD_LIMIT = 12'(WATCHDOG);

    state_t      r_state;
    logic [11:0] r_cnt;
    logic        r_pend_redraw;
    logic        r_pend_move;
    logic        r_skip_erase;
    logic        r_timeout;
    logic [4:0]  r_sh_old_x,   r_sh_new_x,   r_act_old_x,   r_act_new_x;
    logic [5:0]  r_sh_old_y,   r_sh_new_y,   r_act_old_y,   r_act_new_y;
    logic [2:0]  r_sh_old_blk, r_sh_new_blk, r_act_old_blk, r_act_new_blk;

    logic w_wd_hit;
    logic w_tet_phase;
    logic w_tet_window;

    assign w_wd_hit     = (r_cnt == WD_LIMIT);
    assign w_tet_phase  = (r_state == ERASE) || (r_state == DRAW);
    assign w_tet_window = (r_cnt >= 12'd1) && (r_cnt <= 12'd64);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_pend_redraw <= 1'b0;
            r_pend_move   <= 1'b0;
            r_skip_erase  <= 1'b0;
            r_timeout     <= 1'b0;
            r_sh_old_x    <= '0;
            r_sh_old_y    <= '0;
            r_sh_old_blk  <= '0;
            r_sh_new_x    <= '0;
            r_sh_new_y    <= '0;
            r_sh_new_blk  <= '0;
            r_act_old_x   <= '0;
            r_act_old_y   <= '0;
            r_act_old_blk <= '0;
            r_act_new_x   <= '0;
            r_act_new_y   <= '0;
            r_act_new_blk <= '0;
        end else begin
            r_cnt <= r_cnt + 12'd1;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (r_pend_redraw) begin
                        r_state       <= BOARD;
                        r_pend_redraw <= 1'b0;
                        r_skip_erase  <= r_pend_move;
                    end else if (r_pend_move) begin
                        r_state       <= ERASE;
                        r_pend_move   <= 1'b0;
                        r_act_old_x   <= r_sh_old_x;
                        r_act_old_y   <= r_sh_old_y;
                        r_act_old_blk <= r_sh_old_blk;
                        r_act_new_x   <= r_sh_new_x;
                        r_act_new_y   <= r_sh_new_y;
                        r_act_new_blk <= r_sh_new_blk;
                    end
                end
                BOARD: begin
                    if (board_finished) begin
                        r_cnt <= '0;
                        if (r_skip_erase) begin
                            // The repaint already wiped the old piece, so go straight to drawing.
                            r_state       <= DRAW;
                            r_skip_erase  <= 1'b0;
                            r_pend_move   <= 1'b0;
                            r_act_old_x   <= r_sh_old_x;
                            r_act_old_y   <= r_sh_old_y;
                            r_act_old_blk <= r_sh_old_blk;
                            r_act_new_x   <= r_sh_new_x;
                            r_act_new_y   <= r_sh_new_y;
                            r_act_new_blk <= r_sh_new_blk;
                        end else begin
                            r_state <= FINISH;
                        end
                    end else if (w_wd_hit) begin
                        r_state      <= FINISH;
                        r_cnt        <= '0;
                        r_timeout    <= 1'b1;
                        r_skip_erase <= 1'b0;
                    end
                end
                ERASE: begin
                    if (tet_complete) begin
                        r_state <= GAP;
                        r_cnt   <= '0;
                    end else if (w_wd_hit) begin
                        r_state   <= FINISH;
                        r_cnt     <= '0;
                        r_timeout <= 1'b1;
                    end
                end
                GAP: begin
                    r_state <= DRAW;
                    r_cnt   <= '0;
                end
                DRAW: begin
                    if (tet_complete) begin
                        r_state <= FINISH;
                        r_cnt   <= '0;
                    end else if (w_wd_hit) begin
                        r_state   <= FINISH;
                        r_cnt     <= '0;
                        r_timeout <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase

            // Capture comes last so a fresh request wins over the clear of the one being consumed.
            if (redraw_req) begin
                r_pend_redraw <= 1'b1;
            end
            if (move_req) begin
                r_pend_move  <= 1'b1;
                r_sh_old_x   <= old_x;
                r_sh_old_y   <= old_y;
                r_sh_old_blk <= old_block;
                r_sh_new_x   <= new_x;
                r_sh_new_y   <= new_y;
                r_sh_new_blk <= new_block;
            end
        end
    end

    assign board_enable = (r_state == BOARD) && !reset;
    assign tet_enable   = w_tet_phase && !reset;
    assign tet_clear    = (r_state == ERASE) && !reset;
    assign busy         = (r_state != IDLE) && !reset;
    assign done         = (r_state == FINISH) && !reset;
    assign timeout      = r_timeout;
    assign tet_block    = (r_state == ERASE) ? r_act_old_blk : r_act_new_blk;
    assign tet_x_in     = (r_state == ERASE) ? r_act_old_x   : r_act_new_x;
    assign tet_y_in     = (r_state == ERASE) ? r_act_old_y   : r_act_new_y;

    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        if (r_state == BOARD) begin
            vga_x      = board_X;
            vga_y      = board_Y;
            vga_colour = board_colour;
        end else if (w_tet_phase) begin
            vga_x      = tet_X;
            vga_y      = tet_Y;
            vga_colour = tet_colour;
        end
    end

    // Painter pixels lag their enable by one cycle, hence no plot on the entry cycle.
    assign vga_plot = !reset &&
                      (((r_state == BOARD) && (r_cnt != 12'd0) && !board_finished) ||
                       (w_tet_phase && w_tet_window && !tet_complete));
endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 SHALL have ports: clk  in  1  system clock (all logic on posedge); reset  in  1  synchronous, active-high reset.
REQ-002 SHALL have ports: redraw_req  in  1  full-board repaint request (level sampled each clk); move_req  in  1  piece move/redraw request.
REQ-003 SHALL have ports: old_x  in  5,  old_y  in  6,  old_block  in  3  (piece to erase); new_x  in  5,  new_y  in  6,  new_block  in  3  (piece to draw).
REQ-004 SHALL have ports: board_X  in  8,  board_Y  in  7,  board_colour  in  6,  board_finished  in  1  (board painter); board_enable  out  1.
REQ-005 SHALL have ports: tet_X  in  8,  tet_Y  in  7,  tet_colour  in  6,  tet_complete  in  1  (piece painter); tet_enable  out  1,  tet_clear  out  1,  tet_block  out  3,  tet_x_in  out  5,  tet_y_in  out  6.
REQ-006 SHALL have ports: vga_x  out  8,  vga_y  out  7,  vga_colour  out  6,  vga_plot  out  1  (shared VGA write port); busy  out  1;  done  out  1  (one-cycle pulse);  timeout  out  1  (sticky error).
REQ-007 SHALL have parameter: WATCHDOG, default 4095, max cycles any single paint phase may last.

Function
REQ-010 States SHALL be IDLE, BOARD, ERASE, GAP, DRAW, FINISH; one-hot or binary at implementer's choice.
REQ-011 Request capture: pend_redraw SHALL set on any cycle redraw_req=1; pend_move SHALL set on any cycle move_req=1, latching old_*/new_* into shadow registers (later move_req overwrites shadow while pending).
REQ-012 Capture SHALL occur in every state, including during an active phase; shadow registers SHALL NOT change the active phase's outputs.
REQ-013 IDLE: board_enable=0, tet_enable=0, busy=0; if pend_redraw -> BOARD (clear pend_redraw; if pend_move also set, mark skip_erase and keep pend_move); else if pend_move -> ERASE (clear pend_move, copy shadow into active registers).
REQ-014 Redraw SHALL have priority over move when both pending.
REQ-015 BOARD: board_enable=1 (rising edge one cycle after IDLE, since enable was 0 in IDLE); exit on board_finished=1 -> DRAW if skip_erase (copy shadow, clear pend_move, clear skip_erase) else FINISH.
REQ-016 ERASE: tet_enable=1, tet_clear=1, tet_block/tet_x_in/tet_y_in = active old_*; exit on tet_complete=1 -> GAP.
REQ-017 GAP: exactly one cycle with tet_enable=0 (resets painter counter) -> DRAW.
REQ-018 DRAW: tet_enable=1, tet_clear=0, tet_* = active new_*; exit on tet_complete=1 -> FINISH.
REQ-019 FINISH: done=1 for exactly one cycle, enables 0 -> IDLE.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 VGA mux: in BOARD vga_* = board_*; in ERASE/DRAW vga_* = tet_*; else vga_x=0, vga_y=0, vga_colour=0.
REQ-022 vga_plot in BOARD SHALL be 1 from state cycle 1 (cycle 0 = entry) while board_finished=0.
REQ-023 vga_plot in ERASE/DRAW SHALL be 1 on state cycles 1..64 inclusive (painter output registered one cycle late), 0 on cycle 0 and on the tet_complete cycle; exactly 64 plots per phase.
REQ-024 Phase cycle counter 12 bits, cleared on each state entry; reaching WATCHDOG in BOARD/ERASE/DRAW SHALL set timeout=1 and go to FINISH (done still pulses).
REQ-025 timeout SHALL clear only on reset.
REQ-026 Output mux and vga_plot SHALL be combinational from state and counter; all other outputs registered or state-decoded.

Reset
REQ-030 reset=1 SHALL, on the next clk edge, force IDLE, clear pend_redraw, pend_move, skip_erase, timeout, counter, shadow and active registers to 0, regardless of current state.
REQ-031 While reset=1: board_enable=0, tet_enable=0, tet_clear=0, vga_plot=0, busy=0, done=0; requests SHALL be ignored.

Verification
REQ-040 move_req pulse (old 3,5 blk 2; new 3,6 blk 2), painter model completes at cycle 65 -> ERASE with tet_clear=1 at (3,5), 64 plots; GAP 1 cycle with tet_enable=0; DRAW at (3,6), 64 plots; done one cycle; busy drops.
REQ-041 redraw_req and move_req same cycle -> BOARD first, no ERASE phase, then DRAW with new_*, single done pulse.
REQ-042 Second move_req (new 4,6) during ERASE of first -> first sequence completes unchanged, then a second ERASE/DRAW using latched 4,6 without further request.
REQ-043 Painter model never asserts tet_complete -> timeout=1 at cycle WATCHDOG of ERASE, FINISH, done pulse; timeout stays 1 until reset.
REQ-044 reset asserted mid-BOARD -> next cycle IDLE, board_enable=0, vga_plot=0, pending requests lost; subsequent redraw_req restarts cleanly.
REQ-045 Scoreboard: vga_plot never asserted in IDLE/GAP/FINISH; total plots per full board = painter pixel count.
